// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, ALU control codes,
// forwarding select encoding and the ID/EX pipeline payload.
package mips_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RADDR_W   = 5;
  localparam int unsigned ALU_CTL_W = 5;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 5'b00000;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 5'b00001;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 5'b00010;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 5'b00110;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 5'b00111;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR = 5'b01100;
  localparam logic [ALU_CTL_W-1:0] ALU_XOR = 5'b01101;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL = 5'b10000;
  localparam logic [ALU_CTL_W-1:0] ALU_SRL = 5'b11000;
  localparam logic [ALU_CTL_W-1:0] ALU_SRA = 5'b11001;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [RADDR_W-1:0]   rs_addr;
    logic [RADDR_W-1:0]   rt_addr;
    logic [XLEN-1:0]      rs_data;
    logic [XLEN-1:0]      rt_data;
    logic [XLEN-1:0]      imm;
    logic [RADDR_W-1:0]   shamt;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic                 sign;
    logic                 alu_src1;
    logic                 alu_src2;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic [RADDR_W-1:0]   dst_addr;
  } idex_t;

  // A writeback tuple targets this source register; $0 never matches.
  function automatic logic wb_hit(input logic we, input logic [RADDR_W-1:0] dst,
                                  input logic [RADDR_W-1:0] addr);
    return we && (dst != '0) && (dst == addr);
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats
// the value captured in the ID/EX register.
module forward_mux
  import mips_pkg::*;
(
  input  logic [RADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]    i_regval,
  input  logic               i_exmem_reg_write,
  input  logic [RADDR_W-1:0] i_exmem_dst_addr,
  input  logic [XLEN-1:0]    i_exmem_result,
  input  logic               i_memwb_reg_write,
  input  logic [RADDR_W-1:0] i_memwb_dst_addr,
  input  logic [XLEN-1:0]    i_memwb_result,
  output logic [XLEN-1:0]    o_value
);

  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FWD_NONE;
    if (wb_hit(i_exmem_reg_write, i_exmem_dst_addr, i_addr)) begin
      w_sel = FWD_EXMEM;
    end else if (wb_hit(i_memwb_reg_write, i_memwb_dst_addr, i_addr)) begin
      w_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    o_value = i_regval;
    case (w_sel)
      FWD_EXMEM: o_value = i_exmem_result;
      FWD_MEMWB: o_value = i_memwb_result;
      default:   o_value = i_regval;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, WB capture
// bypass and execute-time forwarding into the ALU operands.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic [RADDR_W-1:0]   id_rs_addr,
  input  logic [RADDR_W-1:0]   id_rt_addr,
  input  logic [XLEN-1:0]      id_rs_data,
  input  logic [XLEN-1:0]      id_rt_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [RADDR_W-1:0]   id_shamt,
  input  logic [ALU_CTL_W-1:0] id_alu_ctl,
  input  logic                 id_sign,
  input  logic                 id_alu_src1,
  input  logic                 id_alu_src2,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_reg_write,
  input  logic [RADDR_W-1:0]   id_dst_addr,
  input  logic                 flush,
  input  logic                 exmem_reg_write,
  input  logic [RADDR_W-1:0]   exmem_dst_addr,
  input  logic [XLEN-1:0]      exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [RADDR_W-1:0]   memwb_dst_addr,
  input  logic [XLEN-1:0]      memwb_result,
  output logic                 stall_if_id,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_in_1,
  output logic [XLEN-1:0]      ex_in_2,
  output logic [ALU_CTL_W-1:0] ex_alu_ctl,
  output logic                 ex_sign,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_reg_write,
  output logic [RADDR_W-1:0]   ex_dst_addr,
  output logic [XLEN-1:0]      ex_store_data
);

  idex_t             r_ex;
  idex_t             w_ex_next;
  logic              w_hazard;
  logic              w_bubble;
  logic [XLEN-1:0]   w_fwd_rs;
  logic [XLEN-1:0]   w_fwd_rt;

  // Conservative load-use check: both sources compared regardless of use.
  assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.dst_addr != '0) &&
                    ((r_ex.dst_addr == id_rs_addr) || (r_ex.dst_addr == id_rt_addr));
  assign stall_if_id = w_hazard && !flush;
  assign w_bubble    = flush || w_hazard || !id_valid;

  always_comb begin
    w_ex_next = '0;
    if (!w_bubble) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rs_addr   = id_rs_addr;
      w_ex_next.rt_addr   = id_rt_addr;
      w_ex_next.rs_data   = wb_hit(memwb_reg_write, memwb_dst_addr, id_rs_addr) ?
                            memwb_result : id_rs_data;
      w_ex_next.rt_data   = wb_hit(memwb_reg_write, memwb_dst_addr, id_rt_addr) ?
                            memwb_result : id_rt_data;
      w_ex_next.imm       = id_imm;
      w_ex_next.shamt     = id_shamt;
      w_ex_next.alu_ctl   = id_alu_ctl;
      w_ex_next.sign      = id_sign;
      w_ex_next.alu_src1  = id_alu_src1;
      w_ex_next.alu_src2  = id_alu_src2;
      w_ex_next.mem_read  = id_mem_read;
      w_ex_next.mem_write = id_mem_write;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.dst_addr  = id_dst_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_next;
    end
  end

  forward_mux u_fwd_rs (
    .i_addr            (r_ex.rs_addr),
    .i_regval          (r_ex.rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_dst_addr  (exmem_dst_addr),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_dst_addr  (memwb_dst_addr),
    .i_memwb_result    (memwb_result),
    .o_value           (w_fwd_rs)
  );

  forward_mux u_fwd_rt (
    .i_addr            (r_ex.rt_addr),
    .i_regval          (r_ex.rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_dst_addr  (exmem_dst_addr),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_dst_addr  (memwb_dst_addr),
    .i_memwb_result    (memwb_result),
    .o_value           (w_fwd_rt)
  );

  assign ex_in_1       = r_ex.alu_src1 ? XLEN'(r_ex.shamt) : w_fwd_rs;
  assign ex_in_2       = r_ex.alu_src2 ? r_ex.imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign ex_valid      = r_ex.valid;
  assign ex_alu_ctl    = r_ex.alu_ctl;
  assign ex_sign       = r_ex.sign;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_dst_addr   = r_ex.dst_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios
// plus randomized traffic against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_alu_ctl;
  logic        id_sign, id_alu_src1, id_alu_src2;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic [4:0]  id_dst_addr;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_dst_addr;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_dst_addr;
  logic [31:0] memwb_result;
  logic        stall_if_id, ex_valid;
  logic [31:0] ex_in_1, ex_in_2, ex_store_data;
  logic [4:0]  ex_alu_ctl, ex_dst_addr;
  logic        ex_sign, ex_mem_read, ex_mem_write, ex_reg_write;

  int vec_cnt = 0;
  int err_cnt = 0;

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_ctl(id_alu_ctl), .id_sign(id_sign),
    .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_dst_addr(id_dst_addr), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_dst_addr(exmem_dst_addr),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_dst_addr(memwb_dst_addr), .memwb_result(memwb_result),
    .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_in_1(ex_in_1),
    .ex_in_2(ex_in_2), .ex_alu_ctl(ex_alu_ctl), .ex_sign(ex_sign),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_dst_addr(ex_dst_addr),
    .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the instruction currently sitting in EX, as plain fields.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  sh, ctl;
    logic        sign, s1, s2, mr, mw, rw;
    logic [4:0]  dst;
  } ex_t;

  ex_t m;

  function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] v);
    if (exmem_reg_write && exmem_dst_addr != 0 && exmem_dst_addr == a) return exmem_result;
    if (memwb_reg_write && memwb_dst_addr != 0 && memwb_dst_addr == a) return memwb_result;
    return v;
  endfunction

  function automatic logic m_hazard();
    return m.v && m.mr && m.dst != 0 && (m.dst == id_rs_addr || m.dst == id_rt_addr);
  endfunction

  function automatic logic exp_stall();
    return m_hazard() && !flush;
  endfunction

  function automatic logic [31:0] exp_in1();
    return m.s1 ? {27'b0, m.sh} : mfwd(m.rs, m.rsd);
  endfunction

  function automatic logic [31:0] exp_in2();
    return m.s2 ? m.imm : mfwd(m.rt, m.rtd);
  endfunction

  function automatic logic [14:0] exp_ctrl();
    return {m.v, m.ctl, m.sign, m.mr, m.mw, m.rw, m.dst};
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = '0;
    if (id_valid && !flush && !m_hazard()) begin
      n.v   = 1'b1;
      n.rs  = id_rs_addr;
      n.rt  = id_rt_addr;
      n.rsd = (memwb_reg_write && memwb_dst_addr != 0 && memwb_dst_addr == id_rs_addr)
              ? memwb_result : id_rs_data;
      n.rtd = (memwb_reg_write && memwb_dst_addr != 0 && memwb_dst_addr == id_rt_addr)
              ? memwb_result : id_rt_data;
      n.imm = id_imm;  n.sh = id_shamt;  n.ctl = id_alu_ctl;  n.sign = id_sign;
      n.s1 = id_alu_src1;  n.s2 = id_alu_src2;
      n.mr = id_mem_read;  n.mw = id_mem_write;  n.rw = id_reg_write;
      n.dst = id_dst_addr;
    end
    return n;
  endfunction

  task automatic tick();
    ex_t nx;
    nx = model_next();
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alu_ctl = 0; id_sign = 0; id_alu_src1 = 0;
    id_alu_src2 = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    id_dst_addr = 0; flush = 0;
    exmem_reg_write = 0; exmem_dst_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_dst_addr = 0; memwb_result = 0;
  endtask

  task automatic load_word(input logic [4:0] dst);
    clear_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_dst_addr = dst;
    id_rs_addr = 5'd1; id_alu_ctl = 5'b00010; id_alu_src2 = 1; id_imm = 32'h10;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    m = '0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({ex_valid, ex_alu_ctl, ex_sign, ex_mem_read, ex_mem_write, ex_reg_write,
         ex_dst_addr, ex_in_1, ex_in_2, ex_store_data, stall_if_id} !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: got valid=%b ctl=%b in1=%h in2=%h st=%h stall=%b, expected all 0",
               ex_valid, ex_alu_ctl, ex_in_1, ex_in_2, ex_store_data, stall_if_id);
    end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    load_word(5'd8);
    tick();
    vec_cnt++;
    if ({ex_valid, ex_mem_read, ex_dst_addr} !== {1'b1, 1'b1, 5'd8}) begin
      err_cnt++;
      $display("FAIL lu_load_in_ex: got v=%b mr=%b dst=%0d, expected 1 1 8",
               ex_valid, ex_mem_read, ex_dst_addr);
    end
    clear_inputs();
    id_valid = 1; id_rs_addr = 5'd8; id_rt_addr = 5'd2; id_rs_data = 32'h111;
    id_rt_data = 32'h222; id_dst_addr = 5'd3; id_reg_write = 1; id_alu_ctl = 5'b00010;
    #1;
    vec_cnt++;
    if (stall_if_id !== 1'b1) begin
      err_cnt++; $display("FAIL lu_stall: got %b expected 1", stall_if_id);
    end
    tick();
    vec_cnt++;
    if ({ex_valid, ex_reg_write, stall_if_id} !== 3'b000) begin
      err_cnt++;
      $display("FAIL lu_bubble: got v=%b rw=%b stall=%b expected 0 0 0",
               ex_valid, ex_reg_write, stall_if_id);
    end
    exmem_reg_write = 1; exmem_dst_addr = 5'd8; exmem_result = 32'hDEAD_BEEF;
    tick();
    vec_cnt++;
    if ({ex_valid, ex_in_1, ex_in_2} !== {1'b1, 32'hDEAD_BEEF, 32'h222}) begin
      err_cnt++;
      $display("FAIL lu_forward: got v=%b in1=%h in2=%h expected 1 deadbeef 00000222",
               ex_valid, ex_in_1, ex_in_2);
    end
  endtask

  task automatic test_double_match();
    clear_inputs();
    id_valid = 1; id_rs_addr = 5'd5; id_rs_data = 32'h33; id_dst_addr = 5'd7;
    tick();
    clear_inputs();
    exmem_reg_write = 1; exmem_dst_addr = 5'd5; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_dst_addr = 5'd5; memwb_result = 32'h22;
    #1;
    vec_cnt++;
    if (ex_in_1 !== 32'h11) begin
      err_cnt++; $display("FAIL dbl_exmem_wins: got %h expected 00000011", ex_in_1);
    end
    exmem_reg_write = 0;
    #1;
    vec_cnt++;
    if (ex_in_1 !== 32'h22) begin
      err_cnt++; $display("FAIL dbl_memwb_only: got %h expected 00000022", ex_in_1);
    end
    memwb_reg_write = 0;
    #1;
    vec_cnt++;
    if (ex_in_1 !== 32'h33) begin
      err_cnt++; $display("FAIL dbl_regval: got %h expected 00000033", ex_in_1);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    id_valid = 1; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
    tick();
    clear_inputs();
    exmem_reg_write = 1; exmem_dst_addr = 5'd0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_dst_addr = 5'd0; memwb_result = 32'hFFFF_FFFF;
    #1;
    vec_cnt++;
    if ({ex_in_1, ex_store_data} !== 64'h0) begin
      err_cnt++;
      $display("FAIL zero_reg: got in1=%h st=%h expected 0 0", ex_in_1, ex_store_data);
    end
  endtask

  task automatic test_shift();
    clear_inputs();
    id_valid = 1; id_alu_ctl = 5'b10000; id_shamt = 5'd7; id_alu_src1 = 1;
    id_rs_addr = 5'd0; id_rt_addr = 5'd9; id_rs_data = 32'h5A5A_5A5A;
    id_dst_addr = 5'd10; id_reg_write = 1;
    tick();
    clear_inputs();
    exmem_reg_write = 1; exmem_dst_addr = 5'd9; exmem_result = 32'h8000_0001;
    #1;
    vec_cnt++;
    if ({ex_in_1, ex_in_2, ex_alu_ctl, ex_store_data} !==
        {32'h7, 32'h8000_0001, 5'b10000, 32'h8000_0001}) begin
      err_cnt++;
      $display("FAIL shift_sll: got in1=%h in2=%h ctl=%b st=%h expected 00000007 80000001 10000 80000001",
               ex_in_1, ex_in_2, ex_alu_ctl, ex_store_data);
    end
  endtask

  task automatic test_capture_bypass();
    clear_inputs();
    id_valid = 1; id_rs_addr = 5'd4; id_rt_addr = 5'd4; id_rs_data = 32'hAAAA;
    id_rt_data = 32'hBBBB;
    memwb_reg_write = 1; memwb_dst_addr = 5'd4; memwb_result = 32'h5555;
    tick();
    clear_inputs();
    #1;
    vec_cnt++;
    if ({ex_in_1, ex_store_data} !== {32'h5555, 32'h5555}) begin
      err_cnt++;
      $display("FAIL capture_bypass: got in1=%h st=%h expected 00005555 00005555",
               ex_in_1, ex_store_data);
    end
  endtask

  task automatic test_flush_hazard();
    load_word(5'd6);
    tick();
    clear_inputs();
    id_valid = 1; id_rt_addr = 5'd6; id_rs_addr = 5'd1; id_reg_write = 1;
    id_dst_addr = 5'd2; flush = 1;
    #1;
    vec_cnt++;
    if (stall_if_id !== 1'b0) begin
      err_cnt++; $display("FAIL flush_no_stall: got %b expected 0", stall_if_id);
    end
    tick();
    vec_cnt++;
    if ({ex_valid, ex_reg_write, ex_dst_addr} !== 7'b0) begin
      err_cnt++;
      $display("FAIL flush_bubble: got v=%b rw=%b dst=%0d expected 0 0 0",
               ex_valid, ex_reg_write, ex_dst_addr);
    end
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    id_valid = 1; id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_rs_data = 32'h1234;
    id_rt_data = 32'h5678; id_alu_ctl = 5'b00010; id_reg_write = 1; id_dst_addr = 5'd3;
    tick();
    vec_cnt++;
    if ({ex_valid, ex_in_1, ex_in_2} !== {1'b1, 32'h1234, 32'h5678}) begin
      err_cnt++;
      $display("FAIL midop_loaded: got v=%b in1=%h in2=%h expected 1 00001234 00005678",
               ex_valid, ex_in_1, ex_in_2);
    end
    #3;
    reset_n = 0;
    #1;
    vec_cnt++;
    if ({ex_valid, ex_alu_ctl, ex_reg_write, ex_dst_addr, ex_in_1, ex_in_2,
         ex_store_data, stall_if_id} !== '0) begin
      err_cnt++;
      $display("FAIL midop_reset: got v=%b ctl=%b rw=%b dst=%0d in1=%h in2=%h expected all 0",
               ex_valid, ex_alu_ctl, ex_reg_write, ex_dst_addr, ex_in_1, ex_in_2);
    end
    clear_inputs();
    m = '0;
    #2;
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_valid        = ($urandom_range(0, 7) != 0);
      id_rs_addr      = 5'($urandom_range(0, 3));
      id_rt_addr      = 5'($urandom_range(0, 3));
      id_rs_data      = $urandom;
      id_rt_data      = $urandom;
      id_imm          = $urandom;
      id_shamt        = 5'($urandom);
      id_alu_ctl      = 5'($urandom);
      id_sign         = 1'($urandom);
      id_alu_src1     = ($urandom_range(0, 3) == 0);
      id_alu_src2     = ($urandom_range(0, 2) == 0);
      id_mem_read     = ($urandom_range(0, 2) == 0);
      id_mem_write    = ($urandom_range(0, 4) == 0);
      id_reg_write    = 1'($urandom);
      id_dst_addr     = 5'($urandom_range(0, 3));
      flush           = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom);
      exmem_dst_addr  = 5'($urandom_range(0, 3));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_dst_addr  = 5'($urandom_range(0, 3));
      memwb_result    = $urandom;
      #1;
      vec_cnt++;
      if (stall_if_id !== exp_stall()) begin
        err_cnt++; $display("FAIL rnd_stall[%0d]: got %b expected %b", i, stall_if_id, exp_stall());
      end
      vec_cnt++;
      if (ex_in_1 !== exp_in1()) begin
        err_cnt++; $display("FAIL rnd_in1[%0d]: got %h expected %h", i, ex_in_1, exp_in1());
      end
      vec_cnt++;
      if (ex_in_2 !== exp_in2()) begin
        err_cnt++; $display("FAIL rnd_in2[%0d]: got %h expected %h", i, ex_in_2, exp_in2());
      end
      vec_cnt++;
      if (ex_store_data !== mfwd(m.rt, m.rtd)) begin
        err_cnt++;
        $display("FAIL rnd_store[%0d]: got %h expected %h", i, ex_store_data, mfwd(m.rt, m.rtd));
      end
      vec_cnt++;
      if ({ex_valid, ex_alu_ctl, ex_sign, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_dst_addr} !== exp_ctrl()) begin
        err_cnt++;
        $display("FAIL rnd_ctrl[%0d]: got %b expected %b", i,
                 {ex_valid, ex_alu_ctl, ex_sign, ex_mem_read, ex_mem_write, ex_reg_write,
                  ex_dst_addr}, exp_ctrl());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_double_match();
    test_zero_reg();
    test_shift();
    test_capture_bypass();
    test_flush_hazard();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
